spike_rate_encoder: RTL and testbench

Upstream stage of `binary_lif_neuron`: converts one W-bit intensity sample into a binary spike train of WINDOW timesteps, driven onto the neuron's `in_bit`. Samples arrive over a valid/ready handshake, and one window is encoded per accepted sample. The block has two encoding modes: a deterministic sigma-delta accumulator with exact spike counts, and a stochastic LFSR comparator. At the end of each window it reports the spike count for that window.

---
 rtl/snn_pkg.sv | 18 +
 rtl/lfsr_galois16.sv | 26 ++
 rtl/spike_rate_encoder.sv | 117 +++++++++++
 tb/tb_spike_rate_encoder.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared constants and types for the spiking front-end blocks.
package snn_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

  localparam logic [15:0] LFSR_MASK = 16'hB400;

  localparam int ENC_SIGMA_DELTA = 0;
  localparam int ENC_LFSR        = 1;

  typedef enum logic {IDLE, RUN} enc_state_t;

endpackage

// File: rtl/lfsr_galois16.sv
// 16-bit right-shifting Galois LFSR; advances only when en is high.
module lfsr_galois16
  import snn_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (en) q_d = {1'b0, q_q[15:1]} ^ (q_q[0] ? LFSR_MASK : 16'h0000);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= seed;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/spike_rate_encoder.sv
// Rate encoder: turns one accepted intensity sample into a WINDOW-step spike
// train (sigma-delta or LFSR comparator) and reports the window's spike count.
module spike_rate_encoder
  import snn_pkg::*;
#(
  parameter int          W         = 8,
  parameter int          WINDOW    = 16,
  parameter int          MODE      = 0,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  localparam int         CW        = clog2(WINDOW + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [W-1:0]  s_intensity,
  output logic          spike_out,
  output logic          spike_valid,
  output logic          frame_done,
  output logic [CW-1:0] spike_count
);

  localparam int SW = clog2(WINDOW);

  enc_state_t    state_q, state_d;
  logic [SW-1:0] step_q;
  logic [W-1:0]  int_q;
  logic [CW-1:0] cnt_q;
  logic          spike_out_q, spike_valid_q;
  logic          fin_q, frame_done_q;
  logic [CW-1:0] fin_cnt_q, spike_count_q;

  logic last, accept, run, spike;

  assign last    = (state_q == RUN) && (step_q == SW'(WINDOW - 1));
  assign s_ready = !clear && ((state_q == IDLE) || last);
  assign accept  = s_valid && s_ready;
  // clear freezes every datapath register, including the spike source
  assign run     = (state_q == RUN) && !clear;

  generate
    if (MODE == ENC_LFSR) begin : g_lfsr
      localparam logic [15:0] LOW = 16'((1 << W) - 1);
      logic [15:0] lfsr_q;

      lfsr_galois16 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (run),
        .seed  ((LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED),
        .q     (lfsr_q)
      );

      assign spike = (lfsr_q & LOW) < 16'(int_q);
    end else begin : g_sd
      // Residue only; the carry (bit W of the sum) is the spike itself.
      logic [W-1:0] acc_q;
      logic [W:0]   sum;

      assign sum   = {1'b0, acc_q} + {1'b0, int_q};
      assign spike = sum[W];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      acc_q <= '0;
        else if (accept) acc_q <= '0;
        else if (run)    acc_q <= sum[W-1:0];
      end
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = RUN;
      RUN:  if (clear || (last && !accept)) state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      step_q        <= '0;
      int_q         <= '0;
      cnt_q         <= '0;
      spike_out_q   <= 1'b0;
      spike_valid_q <= 1'b0;
      fin_q         <= 1'b0;
      fin_cnt_q     <= '0;
      frame_done_q  <= 1'b0;
      spike_count_q <= '0;
    end else begin
      state_q       <= state_d;
      spike_valid_q <= run;
      spike_out_q   <= run && spike;
      // Final count is staged so a back-to-back accept can zero cnt_q.
      fin_q         <= run && last;
      if (run && last) fin_cnt_q <= cnt_q + CW'(spike);
      frame_done_q  <= fin_q;
      if (fin_q) spike_count_q <= fin_cnt_q;
      if (accept) begin
        int_q  <= s_intensity;
        cnt_q  <= '0;
        step_q <= '0;
      end else if (run) begin
        cnt_q  <= cnt_q + CW'(spike);
        step_q <= last ? '0 : step_q + SW'(1);
      end
    end
  end

  assign spike_out   = spike_out_q;
  assign spike_valid = spike_valid_q;
  assign frame_done  = frame_done_q;
  assign spike_count = spike_count_q;

endmodule

// File: tb/tb_spike_rate_encoder.sv
// Drives a sigma-delta and an LFSR encoder with shared stimulus and checks both
// every cycle against a window-level model plus a few hand-computed literals.
module tb_spike_rate_encoder;

  localparam int W = 8, WINDOW = 16, CW = 5;

  logic clk, rst_n, clear, s_valid;
  logic [W-1:0] s_intensity;
  logic rdy0, so0, sv0, fd0, rdy1, so1, sv1, fd1;
  logic [CW-1:0] cnt0, cnt1;

  spike_rate_encoder #(.W(W), .WINDOW(WINDOW), .MODE(0), .LFSR_SEED(16'hACE1)) u_sd (
    .clk(clk), .rst_n(rst_n), .clear(clear), .s_valid(s_valid), .s_ready(rdy0),
    .s_intensity(s_intensity), .spike_out(so0), .spike_valid(sv0),
    .frame_done(fd0), .spike_count(cnt0));

  spike_rate_encoder #(.W(W), .WINDOW(WINDOW), .MODE(1), .LFSR_SEED(16'hACE1)) u_lf (
    .clk(clk), .rst_n(rst_n), .clear(clear), .s_valid(s_valid), .s_ready(rdy1),
    .s_intensity(s_intensity), .spike_out(so1), .spike_valid(sv1),
    .frame_done(fd1), .spike_count(cnt1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tot = 0, n_pass = 0;

  // Window-level model: k = timesteps already emitted in the current window.
  bit m_busy, p_fin, e_sv, e_so0, e_so1, e_fd;
  int m_k, m_I, m_n0, m_n1, m_lfsr, p_cnt0, p_cnt1, e_cnt0, e_cnt1;

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
  endtask

  function automatic int lfsr_next(input int s);
    int r;
    r = s >> 1;
    if (s & 1) r = r ^ 'hB400;
    return r;
  endfunction

  function automatic bit m_ready();
    return !clear && (!m_busy || m_k == WINDOW - 1);
  endfunction

  task automatic m_reset();
    m_busy = 0; m_k = 0; m_I = 0; m_n0 = 0; m_n1 = 0; m_lfsr = 'hACE1;
    p_fin = 0; p_cnt0 = 0; p_cnt1 = 0;
    e_sv = 0; e_so0 = 0; e_so1 = 0; e_fd = 0; e_cnt0 = 0; e_cnt1 = 0;
  endtask

  task automatic model_edge();
    bit acc, run;
    int k1, s0, s1;
    acc = s_valid && m_ready();
    run = m_busy && !clear;
    e_fd = p_fin;
    if (p_fin) begin e_cnt0 = p_cnt0; e_cnt1 = p_cnt1; end
    p_fin = 0; e_sv = run; e_so0 = 0; e_so1 = 0;
    if (run) begin
      k1 = m_k + 1;
      // sigma-delta emits floor(k*I/2^W) spikes after k steps
      s0 = (k1 * m_I) / (1 << W) - (m_k * m_I) / (1 << W);
      s1 = ((m_lfsr % (1 << W)) < m_I) ? 1 : 0;
      m_lfsr = lfsr_next(m_lfsr);
      m_n0 += s0; m_n1 += s1;
      e_so0 = s0[0]; e_so1 = s1[0];
      if (k1 == WINDOW) begin
        p_fin = 1; p_cnt0 = m_n0; p_cnt1 = m_n1; m_busy = 0;
      end else m_k = k1;
    end
    if (clear) m_busy = 0;
    if (acc) begin m_busy = 1; m_k = 0; m_I = s_intensity; m_n0 = 0; m_n1 = 0; end
  endtask

  task automatic tick();
    #1;
    chk("s_ready_sd", rdy0, m_ready());
    chk("s_ready_lf", rdy1, m_ready());
    @(posedge clk);
    model_edge();
    #1;
    chk("spike_valid_sd", sv0, e_sv);   chk("spike_valid_lf", sv1, e_sv);
    chk("spike_out_sd", so0, e_so0);    chk("spike_out_lf", so1, e_so1);
    chk("frame_done_sd", fd0, e_fd);    chk("frame_done_lf", fd1, e_fd);
    chk("spike_count_sd", cnt0, e_cnt0); chk("spike_count_lf", cnt1, e_cnt1);
  endtask

  task automatic drive(input bit v, input int i, input bit c);
    s_valid = v; s_intensity = W'(i); clear = c;
  endtask

  task automatic check_reset_state(input string nm);
    chk({nm, "_outs_sd"}, {so0, sv0, fd0, cnt0}, 0);
    chk({nm, "_outs_lf"}, {so1, sv1, fd1, cnt1}, 0);
    chk({nm, "_ready"}, {rdy0, rdy1}, 3);
  endtask

  // Reset asserted between edges; outputs must collapse before the next edge.
  task automatic async_reset();
    drive(0, 0, 0);
    #3 rst_n = 1'b0;
    #1 check_reset_state("async_reset");
    m_reset();
    #2 rst_n = 1'b1;
  endtask

  logic [15:0] pat;
  logic [2:0]  f3;
  int n_acc, svcnt, rises, nfd, tot, nsp, fdc6;
  int fdc[2];
  bit prev, acc_now, fd_seen;

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0);
    m_reset();
    #12 check_reset_state("reset");
    #1 rst_n = 1'b1;

    // 1: intensity 128 -> alternating train, count 8
    drive(1, 128, 0); tick(); drive(0, 0, 0);
    for (int k = 0; k < 16; k++) begin tick(); pat[k] = so0; end
    chk("t1_pattern", pat, 16'hAAAA);
    tick();
    chk("t1_frame_done", fd0, 1);
    chk("t1_count", cnt0, 8);

    // 2: 255 then 0 back-to-back, the second sample held until taken
    drive(1, 255, 0); n_acc = 0; svcnt = 0; rises = 0; nfd = 0; prev = 0;
    for (int k = 0; k < 36; k++) begin
      acc_now = s_valid && m_ready();
      tick();
      if (acc_now) begin n_acc++; if (n_acc == 1) s_intensity = 0; else s_valid = 0; end
      if (sv0) svcnt++;
      if (sv0 && !prev) rises++;
      prev = sv0;
      if (fd0) begin if (nfd < 2) fdc[nfd] = cnt0; nfd++; end
    end
    chk("t2_valid_cycles", svcnt, 32);
    chk("t2_valid_unbroken", rises, 1);
    chk("t2_frames", nfd, 2);
    chk("t2_count_a", fdc[0], 15);
    chk("t2_count_b", fdc[1], 0);

    // 3: LFSR from seed, 64 windows of intensity 64
    async_reset();
    drive(1, 64, 0); n_acc = 0; tot = 0; nsp = 0; f3 = '0;
    for (int k = 0; k < 64 * WINDOW + 4; k++) begin
      acc_now = s_valid && m_ready();
      tick();
      if (acc_now) begin n_acc++; if (n_acc == 64) s_valid = 0; end
      if (sv1) begin if (nsp < 3) f3[nsp] = so1; nsp++; tot += so1; end
    end
    chk("t3_steps", nsp, 64 * WINDOW);
    chk("t3_first3", f3, 3'b100);
    chk("t3_rate_near_256", (tot >= 192 && tot <= 320) ? 1 : 0, 1);

    // 4: clear at step 5 while a new sample waits
    drive(1, 200, 0); tick();
    for (int k = 0; k < 5; k++) tick();
    drive(1, 77, 1);
    #1 chk("t4_ready_blocked", rdy0, 0);
    tick();
    chk("t4_valid_dropped", {sv0, so0, sv1, so1}, 0);
    drive(0, 0, 0); fd_seen = 0;
    for (int k = 0; k < 20; k++) begin tick(); if (fd0 || fd1) fd_seen = 1; end
    chk("t4_no_frame_done", fd_seen, 0);
    chk("t4_count_held", cnt0, 4);

    // 6: intensity churn while the held sample waits
    drive(1, 128, 0); tick(); fdc6 = -1;
    for (int k = 0; k < 20; k++) begin
      s_intensity = W'($urandom);
      acc_now = s_valid && m_ready();
      tick();
      if (acc_now) s_valid = 0;
      if (fd0 && fdc6 < 0) fdc6 = cnt0;
    end
    chk("t6_count_unaffected", fdc6, 8);
    drive(0, 0, 0);
    for (int k = 0; k < 20; k++) tick();

    // 5: reset mid-window, LFSR restarts from the seed
    drive(1, 64, 0); tick(); drive(0, 0, 0);
    for (int k = 0; k < 6; k++) tick();
    async_reset();
    drive(1, 64, 0); tick(); drive(0, 0, 0);
    for (int k = 0; k < 3; k++) begin tick(); f3[k] = so1; end
    chk("t5_lfsr_restart", f3, 3'b100);
    for (int k = 0; k < 16; k++) tick();

    // random traffic with boundary intensities, clears and rare resets
    for (int k = 0; k < 600; k++) begin
      case ($urandom_range(0, 3))
        0:       s_intensity = 0;
        1:       s_intensity = 8'hFF;
        default: s_intensity = W'($urandom);
      endcase
      s_valid = ($urandom_range(0, 99) < 70);
      clear   = ($urandom_range(0, 99) < 5);
      if ($urandom_range(0, 299) == 0) async_reset();
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
